// File: rtl/sram_arb_pkg.sv
// Shared types and default geometry for the single-port SRAM arbiter.
// Imported by the response slot and the arbiter top.
package sram_arb_pkg;

    localparam int DEF_BITS   = 80;
    localparam int DEF_DEPTH  = 128;
    localparam int DEF_ADDR_W = 7;

    typedef enum logic { INIT, RUN } state_t;
    typedef enum logic { READ, WRITE } grant_t;

    // Round-robin preference: whoever was not served last wins a tie.
    function automatic grant_t other_grant(input grant_t g);
        return (g == READ) ? WRITE : READ;
    endfunction

endpackage

// File: rtl/sram_resp_hold.sv
// One-entry read response slot: passes sram_q through in the cycle after a read
// and captures it when the consumer stalls, so held data survives Q going undefined.
module sram_resp_hold
    import sram_arb_pkg::*;
#(
    parameter int BITS = DEF_BITS
) (
    input  logic            CLK,
    input  logic            RSTB,
    input  logic            rd_grant,
    input  logic            resp_ready,
    input  logic [BITS-1:0] sram_q,
    output logic            resp_valid,
    output logic [BITS-1:0] resp_data
);

    logic            held;
    logic [BITS-1:0] hold_data;

    // NOTE: sequential state is written with <= only, so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            resp_valid <= 1'b0;
            held       <= 1'b0;
        end else if (rd_grant) begin
            resp_valid <= 1'b1;
            held       <= 1'b0;
        end else if (resp_valid && resp_ready) begin
            resp_valid <= 1'b0;
            held       <= 1'b0;
        end else if (resp_valid) begin
            held       <= 1'b1;
        end
    end

    // NOTE: the payload register carries no reset; resp_data is gated to zero while invalid.
    always_ff @(posedge CLK) begin
        if (resp_valid && !held) begin
            hold_data <= sram_q;
        end
    end

    // NOTE: combinational outputs get a default first so no path can infer a latch.
    always_comb begin
        resp_data = '0;
        if (resp_valid) begin
            resp_data = held ? hold_data : sram_q;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Single-port SRAM controller: zero-fills the macro after reset, then shares the
// port round-robin between a read requester and a write requester.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int BITS   = DEF_BITS,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              CLK,
    input  logic              RSTB,
    input  logic              rd_req_valid,
    output logic              rd_req_ready,
    input  logic [ADDR_W-1:0] rd_req_addr,
    output logic              rd_resp_valid,
    input  logic              rd_resp_ready,
    output logic [BITS-1:0]   rd_resp_data,
    input  logic              wr_req_valid,
    output logic              wr_req_ready,
    input  logic [ADDR_W-1:0] wr_req_addr,
    input  logic [BITS-1:0]   wr_req_data,
    output logic              init_done,
    output logic              sram_ceb,
    output logic              sram_web,
    output logic [ADDR_W-1:0] sram_a,
    output logic [BITS-1:0]   sram_d,
    input  logic [BITS-1:0]   sram_q
);

    state_t            state;
    grant_t            last_grant;
    logic [ADDR_W-1:0] init_cnt;
    logic              started;
    logic              rd_elig;
    logic              wr_elig;
    logic              rd_grant;
    logic              wr_grant;

    // A held, unaccepted response blocks reads; writes are never blocked by it.
    always_comb begin
        rd_elig  = (state == RUN) && rd_req_valid && (!rd_resp_valid || rd_resp_ready);
        wr_elig  = (state == RUN) && wr_req_valid;
        rd_grant = rd_elig && (!wr_elig || other_grant(last_grant) == READ);
        wr_grant = wr_elig && !rd_grant;
    end

    assign rd_req_ready = rd_grant;
    assign wr_req_ready = wr_grant;

    // started keeps the macro disabled until the first edge after reset release.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state      <= INIT;
            last_grant <= WRITE;
            init_cnt   <= '0;
            started    <= 1'b0;
            init_done  <= 1'b0;
        end else begin
            started <= 1'b1;
            if (state == INIT) begin
                if (started) begin
                    if (init_cnt == ADDR_W'(DEPTH - 1)) begin
                        state     <= RUN;
                        init_done <= 1'b1;
                    end else begin
                        init_cnt <= init_cnt + ADDR_W'(1);
                    end
                end
            end else begin
                if (rd_grant) begin
                    last_grant <= READ;
                end else if (wr_grant) begin
                    last_grant <= WRITE;
                end
            end
        end
    end

    always_comb begin
        sram_ceb = 1'b1;
        sram_web = 1'b1;
        sram_a   = '0;
        sram_d   = '0;
        if (state == INIT) begin
            if (started) begin
                sram_ceb = 1'b0;
                sram_web = 1'b0;
                sram_a   = init_cnt;
            end
        end else if (rd_grant) begin
            sram_ceb = 1'b0;
            sram_a   = rd_req_addr;
        end else if (wr_grant) begin
            sram_ceb = 1'b0;
            sram_web = 1'b0;
            sram_a   = wr_req_addr;
            sram_d   = wr_req_data;
        end
    end

    sram_resp_hold #(
        .BITS(BITS)
    ) u_resp_hold (
        .CLK        (CLK),
        .RSTB       (RSTB),
        .rd_grant   (rd_grant),
        .resp_ready (rd_resp_ready),
        .sram_q     (sram_q),
        .resp_valid (rd_resp_valid),
        .resp_data  (rd_resp_data)
    );

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomized bench for sram_port_arbiter with a behavioural macro and a
// transaction-level reference model (shadow array plus response queue).
module tb_sram_port_arbiter;

    localparam int BITS   = 80;
    localparam int DEPTH  = 128;
    localparam int ADDR_W = 7;

    logic              CLK = 1'b0;
    logic              RSTB = 1'b0;
    logic              rd_req_valid = 1'b0;
    logic              rd_req_ready;
    logic [ADDR_W-1:0] rd_req_addr = '0;
    logic              rd_resp_valid;
    logic              rd_resp_ready = 1'b0;
    logic [BITS-1:0]   rd_resp_data;
    logic              wr_req_valid = 1'b0;
    logic              wr_req_ready;
    logic [ADDR_W-1:0] wr_req_addr = '0;
    logic [BITS-1:0]   wr_req_data = '0;
    logic              init_done;
    logic              sram_ceb;
    logic              sram_web;
    logic [ADDR_W-1:0] sram_a;
    logic [BITS-1:0]   sram_d;
    logic [BITS-1:0]   sram_q;

    logic [BITS-1:0] mem [DEPTH];
    logic            scramble = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    logic [BITS-1:0] ref_mem [DEPTH];
    logic [BITS-1:0] resp_q [$];
    bit              last_was_write;

    always #5 CLK = ~CLK;

    sram_port_arbiter dut (
        .CLK           (CLK),
        .RSTB          (RSTB),
        .rd_req_valid  (rd_req_valid),
        .rd_req_ready  (rd_req_ready),
        .rd_req_addr   (rd_req_addr),
        .rd_resp_valid (rd_resp_valid),
        .rd_resp_ready (rd_resp_ready),
        .rd_resp_data  (rd_resp_data),
        .wr_req_valid  (wr_req_valid),
        .wr_req_ready  (wr_req_ready),
        .wr_req_addr   (wr_req_addr),
        .wr_req_data   (wr_req_data),
        .init_done     (init_done),
        .sram_ceb      (sram_ceb),
        .sram_web      (sram_web),
        .sram_a        (sram_a),
        .sram_d        (sram_d),
        .sram_q        (sram_q)
    );

    function automatic logic [BITS-1:0] rand_word();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[BITS-1:0];
    endfunction

    // Behavioural macro: one-cycle read latency, Q is garbage after non-read cycles.
    always @(posedge CLK) begin
        if (scramble) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= rand_word();
        end else if (!sram_ceb && !sram_web) begin
            mem[sram_a] <= sram_d;
        end
        if (!sram_ceb && sram_web) sram_q <= mem[sram_a];
        else                       sram_q <= rand_word();
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Holds reset for a cycle with both requesters asking, then walks the zero-fill.
    task automatic run_init();
        rd_req_valid  = 1'b1;
        wr_req_valid  = 1'b1;
        rd_req_addr   = 7'd5;
        wr_req_addr   = 7'd9;
        wr_req_data   = rand_word();
        rd_resp_ready = 1'b1;
        scramble      = 1'b1;
        @(posedge CLK);
        #1 scramble = 1'b0;
        @(negedge CLK);
        #1;
        check("rst rd_req_ready", 128'(rd_req_ready), 128'(0));
        check("rst wr_req_ready", 128'(wr_req_ready), 128'(0));
        check("rst rd_resp_valid", 128'(rd_resp_valid), 128'(0));
        check("rst rd_resp_data", 128'(rd_resp_data), 128'(0));
        check("rst init_done", 128'(init_done), 128'(0));
        check("rst sram_ceb", 128'(sram_ceb), 128'(1));
        check("rst sram_web", 128'(sram_web), 128'(1));
        check("rst sram_a", 128'(sram_a), 128'(0));
        check("rst sram_d", 128'(sram_d), 128'(0));
        RSTB = 1'b1;
        #1;
        check("cycle0 sram_ceb", 128'(sram_ceb), 128'(1));
        for (int k = 1; k <= DEPTH; k++) begin
            @(posedge CLK);
            #1;
            check("init sram_ceb", 128'(sram_ceb), 128'(0));
            check("init sram_web", 128'(sram_web), 128'(0));
            check("init sram_a", 128'(sram_a), 128'(k - 1));
            check("init sram_d", 128'(sram_d), 128'(0));
            check("init rd_req_ready", 128'(rd_req_ready), 128'(0));
            check("init wr_req_ready", 128'(wr_req_ready), 128'(0));
            check("init init_done", 128'(init_done), 128'(0));
        end
        @(posedge CLK);
        #1;
        check("init_done at DEPTH+1", 128'(init_done), 128'(1));
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        resp_q.delete();
        last_was_write = 1'b1;
    endtask

    // One clock of traffic: drive, compare against the model, advance the model.
    task automatic step(input logic rv, input logic [ADDR_W-1:0] ra, input logic rr,
                        input logic wv, input logic [ADDR_W-1:0] wa, input logic [BITS-1:0] wd);
        bit exp_valid, rd_ok, g_rd, g_wr;
        @(negedge CLK);
        rd_req_valid  = rv;
        rd_req_addr   = ra;
        rd_resp_ready = rr;
        wr_req_valid  = wv;
        wr_req_addr   = wa;
        wr_req_data   = wd;
        #1;
        exp_valid = (resp_q.size() != 0);
        rd_ok     = rv && (!exp_valid || rr);
        g_rd      = rd_ok && (!wv || last_was_write);
        g_wr      = wv && !g_rd;
        check("rd_req_ready", 128'(rd_req_ready), 128'(g_rd));
        check("wr_req_ready", 128'(wr_req_ready), 128'(g_wr));
        check("rd_resp_valid", 128'(rd_resp_valid), 128'(exp_valid));
        if (exp_valid) check("rd_resp_data", 128'(rd_resp_data), 128'(resp_q[0]));
        check("init_done", 128'(init_done), 128'(1));
        if (g_rd) begin
            check("read sram_ceb", 128'(sram_ceb), 128'(0));
            check("read sram_web", 128'(sram_web), 128'(1));
            check("read sram_a", 128'(sram_a), 128'(ra));
        end else if (g_wr) begin
            check("write sram_ceb", 128'(sram_ceb), 128'(0));
            check("write sram_web", 128'(sram_web), 128'(0));
            check("write sram_a", 128'(sram_a), 128'(wa));
            check("write sram_d", 128'(sram_d), 128'(wd));
        end else begin
            check("idle sram_ceb", 128'(sram_ceb), 128'(1));
        end
        if (exp_valid && rr) void'(resp_q.pop_front());
        if (g_rd) begin
            resp_q.push_back(ref_mem[ra]);
            last_was_write = 1'b0;
        end
        if (g_wr) begin
            ref_mem[wa]    = wd;
            last_was_write = 1'b1;
        end
    endtask

    task automatic random_steps(input int n);
        for (int i = 0; i < n; i++) begin
            step($urandom_range(0, 3) != 0, ADDR_W'($urandom_range(0, 7)),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 1) != 0,
                 ADDR_W'($urandom_range(0, 7)), rand_word());
        end
    endtask

    initial begin
        logic [BITS-1:0] aa;
        aa = {10{8'hAA}};
        run_init();

        // zero-fill visible through a read of address 5
        step(1'b1, 7'd5, 1'b1, 1'b0, 7'd0, '0);
        step(1'b0, 7'd0, 1'b1, 1'b0, 7'd0, '0);

        // read immediately after a write to the same address
        step(1'b0, 7'd0, 1'b1, 1'b1, 7'd3, aa);
        step(1'b1, 7'd3, 1'b1, 1'b0, 7'd0, '0);
        step(1'b0, 7'd0, 1'b1, 1'b0, 7'd0, '0);

        // both requesters continuously valid: grants alternate
        for (int i = 0; i < 8; i++) step(1'b1, ADDR_W'(i), 1'b1, 1'b1, ADDR_W'(i + 16), rand_word());

        // stalled consumer: reads blocked, writes flow, read resumes as ready rises
        step(1'b1, 7'd16, 1'b1, 1'b0, 7'd0, '0);
        for (int i = 0; i < 4; i++) step(1'b1, 7'd17, 1'b0, 1'b1, ADDR_W'(i + 40), rand_word());
        step(1'b1, 7'd17, 1'b1, 1'b0, 7'd0, '0);
        step(1'b0, 7'd0, 1'b1, 1'b0, 7'd0, '0);

        // back-to-back reads at full rate
        for (int i = 0; i < 10; i++) step(1'b0, 7'd0, 1'b1, 1'b1, ADDR_W'(i * 3 + 60), rand_word());
        for (int i = 0; i < 10; i++) step(1'b1, ADDR_W'(i * 3 + 60), 1'b1, 1'b0, 7'd0, '0);
        step(1'b0, 7'd0, 1'b1, 1'b0, 7'd0, '0);

        random_steps(2000);

        // reset with a read in flight
        step(1'b1, 7'd3, 1'b1, 1'b0, 7'd0, '0);
        @(posedge CLK);
        #2;
        check("pre-reset rd_resp_valid", 128'(rd_resp_valid), 128'(1));
        RSTB = 1'b0;
        #1;
        check("mid-reset rd_resp_valid", 128'(rd_resp_valid), 128'(0));
        check("mid-reset sram_ceb", 128'(sram_ceb), 128'(1));
        check("mid-reset init_done", 128'(init_done), 128'(0));
        run_init();
        step(1'b0, 7'd0, 1'b1, 1'b0, 7'd0, '0);
        step(1'b1, 7'd3, 1'b1, 1'b0, 7'd0, '0);
        random_steps(300);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
